// File: rtl/mem_preloader.sv
// mem_preloader
// -------------
// Byte-stream boot loader feeding the memory's side-band write port.
// It parses frames of the form
//   A5 | addr[4] (LE) | count[2] (LE) | count x word[4] (LE) | [csum]
// and issues one 32-bit write per word at incrementing addresses.
// A pending write waits while `hold` is high, because the memory ORs this
// write port with the AXI-side one.
//
// Optional feature: define MEM_PRELOADER_CSUM_EN to expect a trailing
// checksum byte (XOR of all address, count and data bytes). Without it the
// frame ends on its final write (or straight after the count when N = 0),
// and `err` is tied low.
//
// Ports
//   ACLK, ARESET           clock, asynchronous active-high reset
//   in_valid/in_data       incoming stream byte
//   in_ready               byte taken on an edge with in_valid & in_ready
//   hold                   memory write port busy; defer the pending write
//   wr_mem_en/addr/data    one-cycle word write (addr[1:0] always 0)
//   busy                   frame in progress
//   done / err             sticky status of the last frame
//   words_written          words written in the current/last frame
module mem_preloader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  hold,
  output logic                  wr_mem_en,
  output logic [ADDR_WIDTH-1:0] wr_mem_addr,
  output logic [DATA_WIDTH-1:0] wr_mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  words_written
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_t;

  state_t                state_reg, state_next;
  logic [1:0]            idx_reg, idx_next;       // byte index within a field
  logic [23:0]           shift_reg, shift_next;   // last three accepted bytes
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [CNT_WIDTH-1:0]  rem_reg, rem_next;       // words still to write
  logic [CNT_WIDTH-1:0]  words_reg, words_next;
  logic                  done_reg, done_next;
`ifdef MEM_PRELOADER_CSUM_EN
  logic                  err_reg, err_next;
  logic [7:0]            csum_reg, csum_next;
`endif

  logic        accept;
  logic [31:0] word_in;      // current byte on top of the three before it
  logic        payload_end;  // last word written, or N = 0 seen in CNT

  // in_ready is gated by reset so nothing is accepted while ARESET is high.
  assign in_ready = ~ARESET & (state_reg != S_WRITE);
  assign accept   = in_valid & in_ready;
  assign word_in  = {in_data, shift_reg};

  assign wr_mem_en     = (state_reg == S_WRITE) & ~hold;
  assign wr_mem_addr   = addr_reg;
  assign wr_mem_data   = data_reg;
  assign busy          = (state_reg != S_IDLE);
  assign done          = done_reg;
  assign words_written = words_reg;
`ifdef MEM_PRELOADER_CSUM_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      shift_reg <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      rem_reg   <= '0;
      words_reg <= '0;
      done_reg  <= 1'b0;
`ifdef MEM_PRELOADER_CSUM_EN
      err_reg   <= 1'b0;
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
      words_reg <= words_next;
      done_reg  <= done_next;
`ifdef MEM_PRELOADER_CSUM_EN
      err_reg   <= err_next;
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    rem_next    = rem_reg;
    words_next  = words_reg;
    done_next   = done_reg;
`ifdef MEM_PRELOADER_CSUM_EN
    err_next    = err_reg;
    csum_next   = csum_reg;
    if (accept && (state_reg == S_ADDR || state_reg == S_CNT || state_reg == S_DATA))
      csum_next = csum_reg ^ in_data;
`endif
    payload_end = 1'b0;

    // Every accepted byte enters the shift register; each multi-byte field
    // is taken from word_in on its last byte, so fields never mix.
    if (accept)
      shift_next = word_in[31:8];

    case (state_reg)
      S_IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          done_next  = 1'b0;
          words_next = '0;
          idx_next   = '0;
`ifdef MEM_PRELOADER_CSUM_EN
          err_next   = 1'b0;
          csum_next  = '0;
`endif
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (accept) begin
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            addr_next  = ADDR_WIDTH'(word_in) & ~ADDR_WIDTH'(3);
            state_next = S_CNT;
          end
        end
      end
      S_CNT: begin
        if (accept) begin
          if (idx_reg[0]) begin
            rem_next = CNT_WIDTH'({in_data, shift_reg[23:16]});
            idx_next = '0;
            if ({in_data, shift_reg[23:16]} == 16'd0)
              payload_end = 1'b1;
            else
              state_next = S_DATA;
          end else begin
            idx_next = 2'd1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            data_next  = DATA_WIDTH'(word_in);
            state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!hold) begin
          addr_next  = addr_reg + ADDR_WIDTH'(4);
          rem_next   = rem_reg - CNT_WIDTH'(1);
          words_next = words_reg + CNT_WIDTH'(1);
          if (rem_reg == CNT_WIDTH'(1))
            payload_end = 1'b1;
          else
            state_next = S_DATA;
        end
      end
`ifdef MEM_PRELOADER_CSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (in_data == csum_reg)
            done_next = 1'b1;
          else
            err_next = 1'b1;
          state_next = S_IDLE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase

    if (payload_end) begin
`ifdef MEM_PRELOADER_CSUM_EN
      state_next = S_CSUM;
`else
      done_next  = 1'b1;
      state_next = S_IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_mem_preloader.sv
// Testbench for mem_preloader: drives framed byte streams (with random gaps,
// random hold and random garbage) and compares the observed word writes and
// status against a frame-level model built from the frame contents.
module tb_mem_preloader;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        hold;
  logic        wr_mem_en;
  logic [31:0] wr_mem_addr;
  logic [31:0] wr_mem_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  mem_preloader #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .hold         (hold),
    .wr_mem_en    (wr_mem_en),
    .wr_mem_addr  (wr_mem_addr),
    .wr_mem_data  (wr_mem_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_written(words_written)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;
  bit rand_mode = 1'b0;   // random inter-byte gaps and random hold

  logic [31:0] cap_a[$];  // every observed write
  logic [31:0] cap_d[$];
  logic [31:0] fw[$];     // words of the frame under test
  logic [7:0]  garb[$];   // bytes sent ahead of the sync byte
  logic [7:0]  fb[$];     // full byte stream of the frame under test
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic        exp_done;
  logic        exp_err;

  always @(negedge ACLK) begin
    if (wr_mem_en) begin
      cap_a.push_back(wr_mem_addr);
      cap_d.push_back(wr_mem_data);
    end
  end

  // Inputs change 1 time unit after the rising edge; outputs are read on the
  // falling edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
    if (rand_mode) hold = ($urandom_range(0, 2) == 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int gap = rand_mode ? $urandom_range(0, 2) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int w = 0; w < 200 && !acc; w++) begin
      @(negedge ACLK);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL byte_accept: in_ready stayed 0 for byte %h, required 1", b);
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int w = 0; w < 300 && !idle; w++) begin
      @(negedge ACLK);
      idle = !busy;
      tick();
    end
    hold = 1'b0;
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL %s_idle: busy stayed 1, required 0", name);
    end
  endtask

  // Serialise garb + frame built from fw into fb.
  task automatic build_frame(input logic [31:0] a, input bit corrupt);
    logic [7:0]  cs = 8'h00;
    logic [15:0] n  = 16'(fw.size());
    logic [7:0]  b;
    fb.delete();
    foreach (garb[i]) fb.push_back(garb[i]);
    garb.delete();
    fb.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      b = a[8*i +: 8];
      fb.push_back(b);
      cs ^= b;
    end
    for (int i = 0; i < 2; i++) begin
      b = n[8*i +: 8];
      fb.push_back(b);
      cs ^= b;
    end
    foreach (fw[k]) begin
      for (int i = 0; i < 4; i++) begin
        b = fw[k][8*i +: 8];
        fb.push_back(b);
        cs ^= b;
      end
    end
`ifdef MEM_PRELOADER_CSUM_EN
    fb.push_back(cs ^ {7'd0, corrupt});
`endif
  endtask

  // Frame-level expectations: words land at the word-aligned start address
  // and every 4 bytes after it (mod 2^32), whatever the checksum says.
  task automatic model_frame(input logic [31:0] a, input bit corrupt);
    logic [31:0] base = {a[31:2], 2'b00};
    exp_a.delete();
    exp_d.delete();
    foreach (fw[i]) begin
      exp_a.push_back(base + 32'(4 * i));
      exp_d.push_back(fw[i]);
    end
`ifdef MEM_PRELOADER_CSUM_EN
    exp_done = !corrupt;
    exp_err  = corrupt;
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
`endif
  endtask

  // Sends one frame, then compares writes and final status.
  task automatic play_frame(input string name, input logic [31:0] a, input bit corrupt);
    int base;
    int got;
    build_frame(a, corrupt);
    model_frame(a, corrupt);
    base = cap_a.size();
    foreach (fb[i]) send_byte(fb[i]);
    wait_idle(name);
    @(negedge ACLK);
    got = cap_a.size() - base;
    $display("frame %s addr=%h n=%0d writes=%0d done=%b err=%b ww=%0d",
             name, a, fw.size(), got, done, err, words_written);
    checks++;
    if (got != exp_a.size()) begin
      failures++;
      $display("FAIL %s_nwrites: got %0d required %0d", name, got, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got; i++) begin
      checks++;
      if (cap_a[base+i] !== exp_a[i] || cap_d[base+i] !== exp_d[i]) begin
        failures++;
        $display("FAIL %s_write%0d: got %h@%h required %h@%h", name, i,
                 cap_d[base+i], cap_a[base+i], exp_d[i], exp_a[i]);
      end
    end
    checks++;
    if ({done, err} !== {exp_done, exp_err}) begin
      failures++;
      $display("FAIL %s_status: got done=%b err=%b required done=%b err=%b",
               name, done, err, exp_done, exp_err);
    end
    checks++;
    if (words_written !== 16'(fw.size())) begin
      failures++;
      $display("FAIL %s_words_written: got %0d required %0d", name, words_written, fw.size());
    end
    tick();
  endtask

  task automatic test_reset();
    ARESET   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    hold     = 1'b0;
    repeat (3) tick();
    @(negedge ACLK);
    checks++;
    if ({in_ready, wr_mem_en, busy, done, err} !== 5'b0 || wr_mem_addr !== 32'd0 ||
        wr_mem_data !== 32'd0 || words_written !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b en=%b busy=%b done=%b err=%b addr=%h data=%h ww=%0d required all 0",
               in_ready, wr_mem_en, busy, done, err, wr_mem_addr, wr_mem_data, words_written);
    end
    in_valid = 1'b0;
    tick();
    ARESET = 1'b0;
    tick();
    @(negedge ACLK);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b busy=%b required rdy=1 busy=0", in_ready, busy);
    end
    tick();
  endtask

  task automatic test_basic();
    fw = '{32'h44332211, 32'h88776655};
    play_frame("basic", 32'h0000_0100, 1'b0);
  endtask

  task automatic test_hold();
    int base = cap_a.size();
    fw = '{32'h44332211, 32'h88776655};
    build_frame(32'h0000_0100, 1'b0);
    for (int i = 0; i <= 10; i++) send_byte(fb[i]);   // through 4th data byte
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      checks++;
      if ({wr_mem_en, in_ready, busy} !== 3'b001 || wr_mem_addr !== 32'h100 ||
          wr_mem_data !== 32'h44332211) begin
        failures++;
        $display("FAIL hold_cycle%0d: got en=%b rdy=%b busy=%b %h@%h required en=0 rdy=0 busy=1 44332211@00000100",
                 c, wr_mem_en, in_ready, busy, wr_mem_data, wr_mem_addr);
      end
      tick();
    end
    hold = 1'b0;
    @(negedge ACLK);
    checks++;
    if (wr_mem_en !== 1'b1 || wr_mem_addr !== 32'h100 || wr_mem_data !== 32'h44332211) begin
      failures++;
      $display("FAIL hold_release: got en=%b %h@%h required en=1 44332211@00000100",
               wr_mem_en, wr_mem_data, wr_mem_addr);
    end
    tick();
    for (int i = 11; i < fb.size(); i++) send_byte(fb[i]);
    wait_idle("hold");
    @(negedge ACLK);
    checks++;
    if (cap_a.size() - base != 2 || cap_a[base+1] !== 32'h104 || cap_d[base+1] !== 32'h88776655) begin
      failures++;
      $display("FAIL hold_second_write: got %0d writes, required 2 with 88776655@00000104",
               cap_a.size() - base);
    end
    checks++;
    if ({done, err} !== 2'b10 || words_written !== 16'd2) begin
      failures++;
      $display("FAIL hold_status: got done=%b err=%b ww=%0d required done=1 err=0 ww=2",
               done, err, words_written);
    end
    $display("frame hold addr=00000100 n=2 writes=%0d done=%b err=%b", cap_a.size() - base, done, err);
    tick();
  endtask

`ifdef MEM_PRELOADER_CSUM_EN
  task automatic test_bad_csum();
    fw = '{32'h44332211, 32'h88776655};
    play_frame("bad_csum", 32'h0000_0100, 1'b1);
  endtask
`endif

  task automatic test_garbage_unaligned();
    garb = '{8'h00, 8'hFF, 8'h5A};
    fw   = '{32'hEFBEADDE};
    play_frame("garbage", 32'h0000_0103, 1'b0);
  endtask

  task automatic test_zero_count();
    int base = cap_a.size();
    logic exp_busy;
    fw.delete();
    build_frame(32'h0000_2000, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(fb[i]);
`ifdef MEM_PRELOADER_CSUM_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    @(negedge ACLK);
    checks++;
    if (busy !== exp_busy) begin
      failures++;
      $display("FAIL zero_busy_after_cnt: got %b required %b", busy, exp_busy);
    end
    tick();
    for (int i = 7; i < fb.size(); i++) send_byte(fb[i]);
    wait_idle("zero");
    @(negedge ACLK);
    checks++;
    if (cap_a.size() != base || {done, err} !== 2'b10 || words_written !== 16'd0) begin
      failures++;
      $display("FAIL zero_result: got writes=%0d done=%b err=%b ww=%0d required writes=0 done=1 err=0 ww=0",
               cap_a.size() - base, done, err, words_written);
    end
    $display("frame zero addr=00002000 n=0 writes=%0d done=%b err=%b", cap_a.size() - base, done, err);
    tick();
  endtask

  task automatic test_reset_midframe();
    int base = cap_a.size();
    fw = '{$urandom, $urandom};
    build_frame(32'h0000_0400, 1'b0);
    for (int i = 0; i <= 8; i++) send_byte(fb[i]);   // sync, addr, count, 2 payload bytes
    ARESET = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({in_ready, wr_mem_en, busy, done, err} !== 5'b0 || wr_mem_addr !== 32'd0 ||
        words_written !== 16'd0 || cap_a.size() != base) begin
      failures++;
      $display("FAIL midframe_reset: got rdy=%b en=%b busy=%b done=%b addr=%h writes=%0d required all 0",
               in_ready, wr_mem_en, busy, done, wr_mem_addr, cap_a.size() - base);
    end
    tick();
    ARESET = 1'b0;
    tick();
    fw = '{$urandom, $urandom, $urandom};
    play_frame("after_reset", 32'h0000_0800, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  g;
    bit          bad;
    rand_mode = 1'b1;
    for (int f = 0; f < 10; f++) begin
      fw.delete();
      repeat ($urandom_range(0, 4)) fw.push_back($urandom);
      garb.delete();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        garb.push_back(g);
      end
      a   = $urandom;
      bad = ($urandom_range(0, 3) == 0);
      if (f == 0) begin   // address wrap past the top of memory
        a  = 32'hFFFF_FFF9;
        fw = '{$urandom, $urandom, $urandom, $urandom};
      end
      play_frame($sformatf("random%0d", f), a, bad);
    end
    rand_mode = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    ARESET   = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    hold     = 1'b0;
    test_reset();
    test_basic();
    test_hold();
`ifdef MEM_PRELOADER_CSUM_EN
    test_bad_csum();
`endif
    test_garbage_unaligned();
    test_zero_count();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
